// File: rtl/seq_divider.sv
// seq_divider
//   Multi-cycle signed integer divider. Accepts two DATA_LEN-bit two's-complement
//   operands and produces the quotient (truncated toward zero) and the remainder
//   (sign follows the dividend). A restoring shift-subtract loop retires one
//   quotient bit per cycle. The result appears DATA_LEN+1 cycles after the
//   accepting edge and is held until the consumer takes it.
//
// Ports
//   clk          in   1         clock, rising edge
//   reset        in   1         synchronous, active-high
//   in_valid     in   1         operands a/b valid
//   in_ready     out  1         divider can accept operands (high only in IDLE)
//   a            in   DATA_LEN  dividend, signed
//   b            in   DATA_LEN  divisor, signed
//   out_valid    out  1         quotient/remainder/div_by_zero valid
//   out_ready    in   1         consumer takes the result
//   quotient     out  DATA_LEN  signed quotient
//   remainder    out  DATA_LEN  signed remainder
//   div_by_zero  out  1         b was zero for this result
module seq_divider #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] quotient,
  output logic [DATA_LEN-1:0] remainder,
  output logic                div_by_zero
);

  localparam int CNT_W = $clog2(DATA_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_LEN-1:0] a_s;
  logic signed [DATA_LEN-1:0] b_s;

  logic [CNT_W-1:0]    count;
  logic [DATA_LEN-1:0] rem_r;     // partial remainder magnitude
  logic [DATA_LEN-1:0] dvd_r;     // dividend bits shift out, quotient bits shift in
  logic [DATA_LEN-1:0] mag_b_r;
  logic                sign_q_r;
  logic                sign_r_r;
  logic                dbz_r;
  logic                out_valid_r;

  logic [DATA_LEN:0]   shifted;
  logic [DATA_LEN:0]   diff;
  logic                ge;
  logic [DATA_LEN-1:0] rem_nxt;
  logic [DATA_LEN-1:0] dvd_nxt;
  logic                accept;
  logic                last_iter;

  // Magnitude as an unsigned value; |MIN| = 2^(DATA_LEN-1) is representable.
  function automatic logic [DATA_LEN-1:0] abs_mag(input logic signed [DATA_LEN-1:0] x);
    logic [DATA_LEN-1:0] u;
    u = x;
    return x[DATA_LEN-1] ? (~u + 1'b1) : u;
  endfunction

  // Apply a sign to an unsigned magnitude, modulo 2^DATA_LEN.
  function automatic logic [DATA_LEN-1:0] apply_sign(input logic [DATA_LEN-1:0] mag,
                                                     input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  assign a_s = a;
  assign b_s = b;

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_r;
  assign accept    = in_valid && in_ready;
  assign last_iter = (count == CNT_W'(DATA_LEN - 1));

  // One restoring step. The shifted value is kept one bit wider so the
  // compare is exact even while |b| is zero and nothing is ever subtracted.
  always_comb begin
    shifted = {rem_r, dvd_r[DATA_LEN-1]};
    diff    = shifted - {1'b0, mag_b_r};
    ge      = (shifted >= {1'b0, mag_b_r});
    rem_nxt = ge ? diff[DATA_LEN-1:0] : shifted[DATA_LEN-1:0];
    dvd_nxt = {dvd_r[DATA_LEN-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (last_iter) state_nxt = DONE;
      DONE: if (out_valid_r && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and iteration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (accept) begin
      count <= '0;
    end else if (state == BUSY) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rem_r    <= '0;
      dvd_r    <= abs_mag(a_s);
      mag_b_r  <= abs_mag(b_s);
      sign_q_r <= a_s[DATA_LEN-1] ^ b_s[DATA_LEN-1];
      sign_r_r <= a_s[DATA_LEN-1];
      dbz_r    <= (b_s == '0);
    end else if (state == BUSY) begin
      rem_r <= rem_nxt;
      dvd_r <= dvd_nxt;
    end
  end

  // Sign-correction and output register: the first DONE cycle loads the
  // results; out_valid rises with them and falls after the handshake.
  // With b == 0 the loop leaves |a| in rem_r, so the sign-corrected
  // remainder is a itself; only the quotient needs overriding.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == DONE && !out_valid_r) begin
      out_valid_r <= 1'b1;
      quotient    <= dbz_r ? '1 : apply_sign(dvd_r, sign_q_r);
      remainder   <= apply_sign(rem_r, sign_r_r);
      div_by_zero <= dbz_r;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int N = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  quotient;
  logic [N-1:0]  remainder;
  logic          div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider #(.DATA_LEN(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // C-semantics reference with the divider's zero/overflow rules.
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    int signed xs, ys;
    xs = x; ys = y;
    z = (y == 0);
    if (y == 0) begin
      q = 32'hFFFF_FFFF; r = x;
    end else if (x == MIN && y == 32'hFFFF_FFFF) begin
      q = MIN; r = 0;
    end else begin
      q = xs / ys; r = xs % ys;
    end
  endtask

  // Present operands, wait for the result (bounded), optionally consume it.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez,
                         input bit chk_lat);
    int lat;
    start_op(x, y);
    wait_result(lat);
    if (chk_lat) check({tag, "_lat"}, lat, 33);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    consume();
  endtask

  initial begin
    logic [31:0] eq, er, ra, rb;
    logic ez;
    int lat;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_div("p100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    run_div("n100_7", -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 1'b1);
    run_div("p100_n7", 32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 1'b1);
    run_div("n100_n7", -32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 1'b1);
    run_div("p5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);
    run_div("n5_0", -32'sd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b1);
    run_div("min_m1", MIN, 32'hFFFF_FFFF, MIN, 32'd0, 1'b0, 1'b1);
    run_div("min_1", MIN, 32'd1, MIN, 32'd0, 1'b0, 1'b1);
    run_div("min_min", MIN, MIN, 32'd1, 32'd0, 1'b0, 1'b0);
    run_div("small_big", 32'd3, 32'd1000, 32'd0, 32'd3, 1'b0, 1'b0);

    // Backpressure: hold the 9/2 result while new operands are offered.
    start_op(32'd9, 32'd2);
    wait_result(lat);
    check("bp_lat", lat, 33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'd77; b = 32'd3;
      @(posedge clk); #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_q", quotient, 32'd4);
      check("bp_r", remainder, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    consume();
    // Nothing was accepted during the stall, so no result should appear.
    repeat (40) @(posedge clk);
    #1;
    check("bp_no_extra", {31'd0, out_valid}, 32'd0);

    // Reset at iteration 10 of 1000/3.
    start_op(32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    run_div("after_rst", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b1);

    // Random signed pairs, consumed immediately.
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      rb = $signed(rb) >>> $urandom_range(0, 31);
      if (i % 25 == 0) rb = 32'd0;
      ref_div(ra, rb, eq, er, ez);
      start_op(ra, rb);
      @(negedge clk);
      out_ready = 1'b1;
      wait_result(lat);
      check("rnd_lat", lat, 33);
      check("rnd_q", quotient, eq);
      check("rnd_r", remainder, er);
      check("rnd_dbz", {31'd0, div_by_zero}, {31'd0, ez});
      @(posedge clk); #1;
      out_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
